// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns Memread/Memwrite commands into one word-aligned
// bus transaction, stalls the pipeline until ack, and returns extended load data.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Memread,
    input  logic        Memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        fault_q, fault_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  f3_q, f3_d;

    logic        cmd, align_ok, f3_ok, legal;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        cmd = Memread | Memwrite;
        case (funct3[1:0])
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        // Store wins over load, so legality is judged against the store set.
        if (Memwrite) f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else          f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                              (funct3 == 3'b100) || (funct3 == 3'b101);
        legal = align_ok & f3_ok;

        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{wdata[7:0]}};
                st_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{wdata[15:0]}};
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wdata;
                st_be    = 4'b1111;
            end
        endcase

        ld_byte = bus_rdata[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        fault_d       = 1'b0;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        lo_d          = lo_q;
        f3_d          = f3_q;
        case (state_q)
            IDLE: begin
                if (cmd) begin
                    if (legal) begin
                        state_d     = BUSY;
                        cnt_d       = 32'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = Memwrite;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_wdata_d = Memwrite ? st_wdata : 32'd0;
                        bus_be_d    = Memwrite ? st_be : 4'b1111;
                        lo_d        = addr[1:0];
                        f3_d        = funct3;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d       = ld_data;
                        rdata_valid_d = 1'b1;
                    end
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        stall = ((state_q == IDLE) && cmd && legal) || (state_q == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            bus_be_q      <= 4'd0;
            lo_q          <= 2'd0;
            f3_q          <= 3'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            fault_q       <= fault_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            lo_q          <= lo_d;
            f3_q          <= f3_d;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign fault       = fault_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit built with TIMEOUT=4: loads, stores,
// illegal requests, bus timeout and reset while a transaction is outstanding.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Memread = 1'b0, Memwrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        stall, rdata_valid, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .Memread(Memread), .Memwrite(Memwrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        cyc();
        Memread = rd; Memwrite = wr; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
        #1;
    endtask

    task automatic drop();
        Memread = 1'b0; Memwrite = 1'b0; bus_ack = 1'b0;
    endtask

    // Load with ack in the first BUSY cycle.
    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] word, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data);
        issue(1'b1, 1'b0, f3, a, 32'd0);
        chk({tag, "_stall_c0"}, stall, 1);
        cyc(); bus_ack = 1'b1; bus_rdata = word; #1;
        chk({tag, "_req_c1"}, bus_req, 1);
        chk({tag, "_we_c1"}, bus_we, 0);
        chk({tag, "_addr"}, bus_addr, exp_addr);
        chk({tag, "_be"}, bus_be, 4'b1111);
        chk({tag, "_stall_c1"}, stall, 1);
        cyc(); bus_ack = 1'b0; #1;
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_req_done"}, bus_req, 0);
        chk({tag, "_valid"}, rdata_valid, 1);
        chk({tag, "_rdata"}, rdata, exp_data);
        cyc(); drop(); #1;
        chk({tag, "_valid_after"}, rdata_valid, 0);
        chk({tag, "_rdata_hold"}, rdata, exp_data);
    endtask

    // Store with ack in the first BUSY cycle.
    task automatic store_chk(input string tag, input logic rd, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] keep_rdata);
        issue(rd, 1'b1, f3, a, wd);
        chk({tag, "_stall_c0"}, stall, 1);
        cyc(); bus_ack = 1'b1; #1;
        chk({tag, "_req"}, bus_req, 1);
        chk({tag, "_we"}, bus_we, 1);
        chk({tag, "_addr"}, bus_addr, exp_addr);
        chk({tag, "_be"}, bus_be, exp_be);
        chk({tag, "_wdata"}, bus_wdata, exp_wd);
        cyc(); bus_ack = 1'b0; #1;
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_novalid"}, rdata_valid, 0);
        chk({tag, "_rdata_keep"}, rdata, keep_rdata);
        cyc(); drop(); #1;
    endtask

    initial begin
        // Reset values
        cyc(); cyc();
        chk("rst_rdata", rdata, 0);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;

        // Loads
        load_chk("lw", 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF);
        load_chk("lb", 3'b000, 32'h103, 32'h80FF1234, 32'h100, 32'hFFFFFF80);
        load_chk("lbu", 3'b100, 32'h103, 32'h80FF1234, 32'h100, 32'h00000080);
        load_chk("lh", 3'b001, 32'h102, 32'h80FF1234, 32'h100, 32'hFFFF80FF);
        load_chk("lhu", 3'b101, 32'h102, 32'h80FF1234, 32'h100, 32'h000080FF);
        load_chk("lb0", 3'b000, 32'h204, 32'h80FF1234, 32'h204, 32'h00000034);

        // Stores; the second one also raises Memread to check store priority
        store_chk("sb", 1'b0, 3'b000, 32'h45, 32'h000000AB, 32'h44, 4'b0010, 32'hABABABAB, 32'h00000034);
        store_chk("sw_both", 1'b1, 3'b010, 32'h48, 32'h12345678, 32'h48, 4'b1111, 32'h12345678, 32'h00000034);
        store_chk("sh_lo", 1'b0, 3'b001, 32'h50, 32'h00001111, 32'h50, 4'b0011, 32'h11111111, 32'h00000034);

        // sh with ack in the fourth BUSY cycle (last one before the timeout)
        issue(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD);
        chk("sh_stall_c0", stall, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(); bus_ack = (i == 4); #1;
            chk("sh_req", bus_req, 1);
            chk("sh_we", bus_we, 1);
            chk("sh_addr", bus_addr, 32'h20);
            chk("sh_be", bus_be, 4'b1100);
            chk("sh_wdata", bus_wdata, 32'hABCDABCD);
            chk("sh_stall", stall, 1);
        end
        cyc(); bus_ack = 1'b0; #1;
        chk("sh_done_stall", stall, 0);
        chk("sh_done_req", bus_req, 0);
        chk("sh_done_novalid", rdata_valid, 0);
        chk("sh_done_nofault", fault, 0);
        chk("sh_done_rdata", rdata, 32'h00000034);
        cyc(); drop(); #1;

        // Misaligned lw
        issue(1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
        chk("mis_stall", stall, 0);
        cyc(); drop(); #1;
        chk("mis_fault", fault, 1);
        chk("mis_req", bus_req, 0);
        chk("mis_stall_c1", stall, 0);
        cyc(); #1;
        chk("mis_fault_clr", fault, 0);
        chk("mis_req_c2", bus_req, 0);

        // Store with load-only funct3
        issue(1'b0, 1'b1, 3'b100, 32'h40, 32'h55);
        chk("f3_stall", stall, 0);
        cyc(); drop(); #1;
        chk("f3_fault", fault, 1);
        chk("f3_req", bus_req, 0);
        cyc(); #1;
        chk("f3_fault_clr", fault, 0);

        // Timeout: bus_ack stays low
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'd0);
        chk("to_stall_c0", stall, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            chk("to_req", bus_req, 1);
            chk("to_stall", stall, 1);
            chk("to_nofault", fault, 0);
        end
        cyc(); #1;
        chk("to_done_req", bus_req, 0);
        chk("to_done_fault", fault, 1);
        chk("to_done_stall", stall, 0);
        chk("to_done_novalid", rdata_valid, 0);
        chk("to_done_rdata", rdata, 32'h00000034);
        cyc(); drop(); #1;
        chk("to_fault_clr", fault, 0);

        // Reset during BUSY, ack arrives the cycle after reset
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
        cyc(); #1;
        chk("rb_req_c1", bus_req, 1);
        cyc(); rst = 1'b1; #1;
        chk("rb_req_c2", bus_req, 1);
        cyc(); rst = 1'b0; drop(); bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
        chk("rb_req", bus_req, 0);
        chk("rb_rdata", rdata, 0);
        chk("rb_addr", bus_addr, 0);
        chk("rb_be", bus_be, 0);
        chk("rb_wdata", bus_wdata, 0);
        chk("rb_stall", stall, 0);
        cyc(); bus_ack = 1'b0; #1;
        chk("rb_novalid", rdata_valid, 0);
        chk("rb_req_late", bus_req, 0);
        chk("rb_rdata_late", rdata, 0);
        chk("rb_fault_late", fault, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
